// File: rtl/vic_irq_source.sv
// vic_irq_source
// Interrupt source side of the vectored interrupt path. Peripheral request
// edges are latched as pending. The lowest-index enabled pending source is
// granted and presented to the core-side controller as a one-cycle o_IRQ
// pulse, with a vector address that stays stable. The next request waits
// until the controller's in-service flag drops and a short gap has elapsed.
//
// Handshake with the controller (o_IRQ / i_in_service):
//   o_IRQ is high for exactly one cycle, with at least one low cycle before
//   and after it. o_ISR_addr and o_irq_id are already valid one cycle before
//   the pulse. They stay constant until the next grant. The controller
//   raises i_in_service when it accepts the request and holds it high until
//   return-from-interrupt. If i_in_service does not rise within ACK_TIMEOUT
//   cycles after the pulse, the request goes back to pending and o_err
//   pulses for one cycle. Requests are never nested.
module vic_irq_source #(
  parameter int          N_SRC       = 8,
  parameter logic [31:0] VEC_BASE    = 32'h0000_0100,
  parameter int          VEC_STRIDE  = 4,
  parameter int          ACK_TIMEOUT = 16,
  parameter int          GAP_CYCLES  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_SRC-1:0]         i_irq_src,
  input  logic [N_SRC-1:0]         i_irq_en,
  input  logic [N_SRC-1:0]         i_pend_clr,
  input  logic                     i_in_service,
  output logic                     o_IRQ,
  output logic [31:0]              o_ISR_addr,
  output logic [$clog2(N_SRC)-1:0] o_irq_id,
  output logic [N_SRC-1:0]         o_pending,
  output logic                     o_busy,
  output logic                     o_err,
  output logic [2:0]               o_dbg_state
);

  localparam int IW      = $clog2(N_SRC);
  localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [N_SRC-1:0] ONE_HOT0 = {{(N_SRC-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP    = 3'd1,
    S_ASSERT   = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_IN_SVC   = 3'd4,
    S_GAP      = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [N_SRC-1:0]  prev_src_q, prev_src_d;
  logic [N_SRC-1:0]  pending_q, pending_d;
  logic [IW-1:0]     irq_id_q, irq_id_d;
  logic [31:0]       isr_addr_q, isr_addr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [N_SRC-1:0]  req_vec;
  logic              any_req;
  logic [IW-1:0]     pick_idx;
  logic [N_SRC-1:0]  edge_set;
  logic [N_SRC-1:0]  grant_clr;
  logic [N_SRC-1:0]  repend_set;

  // Priority pick: lowest enabled pending index wins.
  always_comb begin
    req_vec  = pending_q & i_irq_en;
    any_req  = |req_vec;
    pick_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_vec[i]) begin
        pick_idx = IW'(i);
      end
    end
  end

  // Grant / in-service sequencing and the shared timeout/gap counter.
  always_comb begin
    state_d    = state_q;
    irq_id_d   = irq_id_q;
    isr_addr_d = isr_addr_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    grant_clr  = '0;
    repend_set = '0;
    case (state_q)
      S_IDLE: begin
        // The mask is evaluated only here. A grant already in flight completes.
        if (any_req) begin
          irq_id_d   = pick_idx;
          isr_addr_d = VEC_BASE + (32'(pick_idx) * 32'(VEC_STRIDE));
          grant_clr  = ONE_HOT0 << pick_idx;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        // One cycle so the vector is settled before the IRQ pulse.
        state_d = S_ASSERT;
      end
      S_ASSERT: begin
        cnt_d   = CW'(ACK_TIMEOUT);
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (i_in_service) begin
          cnt_d   = '0;
          state_d = S_IN_SVC;
        end else if (cnt_q <= CW'(1)) begin
          // Controller never accepted: put the request back for a retry.
          err_d      = 1'b1;
          repend_set = ONE_HOT0 << irq_id_q;
          cnt_d      = '0;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_IN_SVC: begin
        if (!i_in_service) begin
          cnt_d   = CW'(GAP_CYCLES);
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Pending bits: a new edge or a re-pend beats a grant clear, which beats a software clear.
  always_comb begin
    prev_src_d = i_irq_src;
    edge_set   = i_irq_src & ~prev_src_q;
    pending_d  = ((pending_q & ~i_pend_clr) & ~grant_clr) | edge_set | repend_set;
  end

  // State registers. During reset the previous-source register tracks the
  // request lines, so lines already high at reset release do not fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      prev_src_q <= i_irq_src;
      pending_q  <= '0;
      irq_id_q   <= '0;
      isr_addr_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_src_q <= prev_src_d;
      pending_q  <= pending_d;
      irq_id_q   <= irq_id_d;
      isr_addr_q <= isr_addr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    o_IRQ       = (state_q == S_ASSERT);
    o_busy      = (state_q != S_IDLE);
    o_err       = err_q;
    o_ISR_addr  = isr_addr_q;
    o_irq_id    = irq_id_q;
    o_pending   = pending_q;
    o_dbg_state = state_q;
  end

endmodule

// File: tb/tb_vic_irq_source.sv
// tb_vic_irq_source
// Directed scenarios followed by a randomized run. Every cycle the DUT is
// compared against a timeline model. The model records when each request
// was granted, acknowledged and released, and derives the outputs from
// those cycle numbers.
module tb_vic_irq_source;

  localparam int          NS       = 8;
  localparam logic [31:0] VBASE    = 32'h0000_0100;
  localparam int          STRIDE   = 4;
  localparam int          ACK_TO   = 16;
  localparam int          GAP      = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [NS-1:0] i_irq_src, i_irq_en, i_pend_clr;
  logic          i_in_service;
  logic          o_IRQ, o_busy, o_err;
  logic [31:0]   o_ISR_addr;
  logic [2:0]    o_irq_id;
  logic [NS-1:0] o_pending;
  logic [2:0]    o_dbg_state;

  vic_irq_source #(
    .N_SRC(NS), .VEC_BASE(VBASE), .VEC_STRIDE(STRIDE),
    .ACK_TIMEOUT(ACK_TO), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst),
    .i_irq_src(i_irq_src), .i_irq_en(i_irq_en), .i_pend_clr(i_pend_clr),
    .i_in_service(i_in_service),
    .o_IRQ(o_IRQ), .o_ISR_addr(o_ISR_addr), .o_irq_id(o_irq_id),
    .o_pending(o_pending), .o_busy(o_busy), .o_err(o_err),
    .o_dbg_state(o_dbg_state)
  );

  // bookkeeping
  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // values to drive before the next rising edge
  logic [NS-1:0] d_src = '0, d_en = '0, d_clr = '0;
  logic          d_svc = 1'b0, d_rst = 1'b1;

  // reference model: event timeline
  logic [NS-1:0] m_pend, m_prev;
  logic          m_busy, m_irq, m_err;
  int            m_id;
  logic [31:0]   m_addr;
  int            m_g, m_a, m_r;   // grant / acknowledge / release cycle numbers

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance the model across one rising edge using the values about to be driven.
  task automatic model_step();
    logic [NS-1:0] setv, gnt, rep, req, lsb;
    int k;
    cyc++;
    m_err = 1'b0;
    if (d_rst) begin
      m_pend = '0; m_prev = d_src; m_busy = 1'b0; m_irq = 1'b0;
      m_id = 0; m_addr = '0;
      return;
    end
    setv = d_src & ~m_prev;
    gnt  = '0;
    rep  = '0;
    req  = m_pend & d_en;
    if (!m_busy) begin
      if (req != '0) begin
        lsb    = req & (~req + NS'(1));
        k      = $clog2(lsb);
        m_id   = k;
        m_addr = VBASE + 32'(k * STRIDE);
        gnt    = lsb;
        m_busy = 1'b1;
        m_g = cyc; m_a = -1; m_r = -1;
      end
    end else if (m_r >= 0) begin
      if (cyc == m_r + GAP) m_busy = 1'b0;
    end else if (m_a >= 0) begin
      if (!d_svc) m_r = cyc;
    end else if (cyc >= m_g + 3) begin
      if (d_svc) m_a = cyc;
      else if (cyc == m_g + 2 + ACK_TO) begin
        m_err = 1'b1;
        rep[m_id] = 1'b1;
        m_busy = 1'b0;
      end
    end
    m_pend = (m_pend & ~d_clr & ~gnt) | setv | rep;
    m_prev = d_src;
    m_irq  = m_busy && (cyc == m_g + 1);
  endtask

  task automatic compare_all();
    chk("irq",     32'(o_IRQ),     32'(m_irq));
    chk("busy",    32'(o_busy),    32'(m_busy));
    chk("err",     32'(o_err),     32'(m_err));
    chk("pending", 32'(o_pending), 32'(m_pend));
    chk("irq_id",  32'(o_irq_id),  32'(m_id));
    chk("addr",    o_ISR_addr,     m_addr);
  endtask

  // driver: one clock cycle, called at a falling edge
  task automatic tick();
    i_irq_src    = d_src;
    i_irq_en     = d_en;
    i_pend_clr   = d_clr;
    i_in_service = d_svc;
    rst          = d_rst;
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    d_clr = '0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Controller side for a request whose IRQ pulse is visible now.
  task automatic ack_after_irq();
    d_svc = 1'b1; tick(); tick();
    d_svc = 1'b0; tick(); tick(); tick();
  endtask

  // Called right after a grant cycle.
  task automatic serve();
    tick();
    chk("serve_irq", 32'(o_IRQ), 32'd1);
    ack_after_irq();
  endtask

  int k_found;
  int ctl_phase, ctl_cnt;

  initial begin
    rst = 1'b1; i_irq_src = '0; i_irq_en = '0; i_pend_clr = '0; i_in_service = 1'b0;
    @(negedge clk);

    // reset state
    d_rst = 1'b1; ticks(3);
    chk("rst_irq", 32'(o_IRQ), 32'd0);
    chk("rst_addr", o_ISR_addr, 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_pending", 32'(o_pending), 32'd0);
    d_rst = 1'b0; d_en = 8'hFF; tick();

    // single request from source 3
    d_src = 8'h08; tick();
    chk("single_pend", 32'(o_pending), 32'h08);
    tick();
    chk("single_id", 32'(o_irq_id), 32'd3);
    chk("single_addr", o_ISR_addr, 32'h10C);
    chk("single_pre_irq", 32'(o_IRQ), 32'd0);
    tick();
    chk("single_irq", 32'(o_IRQ), 32'd1);
    chk("single_pend_clr", 32'(o_pending), 32'h00);
    tick();
    chk("single_irq_fall", 32'(o_IRQ), 32'd0);
    d_svc = 1'b1; ticks(3);
    d_svc = 1'b0; ticks(3);
    chk("single_idle", 32'(o_busy), 32'd0);

    // priority: 2 and 5 together
    d_src = 8'h00; tick();
    d_src = 8'h24; tick();
    chk("prio_pend", 32'(o_pending), 32'h24);
    tick();
    chk("prio_first_addr", o_ISR_addr, 32'h108);
    ticks(2);
    d_svc = 1'b1; ticks(2);
    d_svc = 1'b0;
    k_found = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (o_IRQ) begin k_found = k; break; end
    end
    chk("prio_latency", 32'(k_found), 32'(GAP + 3));
    chk("prio_second_addr", o_ISR_addr, 32'h114);
    chk("prio_second_id", 32'(o_irq_id), 32'd5);
    ack_after_irq();

    // masking
    d_src = 8'h00; d_en = 8'hF7; tick();
    d_src = 8'h08; ticks(4);
    chk("mask_noirq", 32'(o_busy), 32'd0);
    chk("mask_pend", 32'(o_pending), 32'h08);
    d_en = 8'hFF; tick();
    chk("mask_grant_id", 32'(o_irq_id), 32'd3);
    serve();

    // acknowledge timeout
    d_src = 8'h00; tick();
    d_src = 8'h08; tick(); tick(); tick();
    chk("to_irq", 32'(o_IRQ), 32'd1);
    k_found = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (o_err) begin k_found = k; break; end
    end
    chk("to_delay", 32'(k_found), 32'(ACK_TO + 1));
    chk("to_repend", 32'(o_pending), 32'h08);
    tick();
    serve();

    // set, grant clear and software clear in the same cycle
    d_src = 8'h00; d_en = 8'hFD; tick();
    d_src = 8'h02; tick();
    d_src = 8'h00; tick();
    chk("sc_masked_pend", 32'(o_pending), 32'h02);
    d_src = 8'h02; d_en = 8'hFF; d_clr = 8'h02; tick();
    chk("sc_pend_kept", 32'(o_pending), 32'h02);
    chk("sc_grant_id", 32'(o_irq_id), 32'd1);
    serve();
    tick();
    chk("sc_regrant_busy", 32'(o_busy), 32'd1);
    serve();

    // reset in the middle of an unacknowledged request, source 0 held high
    d_src = 8'h00; tick();
    d_src = 8'h01; tick(); tick(); tick(); ticks(3);
    d_rst = 1'b1; ticks(2);
    chk("rst2_irq", 32'(o_IRQ), 32'd0);
    chk("rst2_err", 32'(o_err), 32'd0);
    chk("rst2_id", 32'(o_irq_id), 32'd0);
    chk("rst2_pending", 32'(o_pending), 32'd0);
    d_rst = 1'b0; ticks(6);
    chk("rst2_quiet", 32'(o_busy), 32'd0);
    d_src = 8'h00; tick();
    d_src = 8'h01; tick(); tick();
    chk("rst2_regrant_addr", o_ISR_addr, 32'h100);
    serve();

    // randomized run
    ctl_phase = 0; ctl_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      if (m_irq) begin
        if ($urandom_range(0, 4) == 0) ctl_phase = 0;
        else begin ctl_phase = 1; ctl_cnt = $urandom_range(0, 5); end
      end
      case (ctl_phase)
        1: begin
          if (ctl_cnt == 0) begin ctl_phase = 2; ctl_cnt = $urandom_range(1, 6); d_svc = 1'b1; end
          else begin ctl_cnt--; d_svc = 1'b0; end
        end
        2: begin
          if (ctl_cnt == 0) begin ctl_phase = 0; d_svc = 1'b0; end
          else begin ctl_cnt--; d_svc = 1'b1; end
        end
        default: d_svc = 1'b0;
      endcase
      d_src = d_src ^ (NS'($urandom) & NS'($urandom) & NS'($urandom));
      d_en  = ($urandom_range(0, 9) == 0) ? NS'($urandom) : 8'hFF;
      d_clr = ($urandom_range(0, 19) == 0) ? (NS'($urandom) & NS'($urandom)) : '0;
      d_rst = ($urandom_range(0, 599) == 0);
      if (d_rst) ctl_phase = 0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
